// File: rtl/leela_vga_pkg.sv
// Shared types and Wishbone constants for the leela VGA frame-buffer fetch path.
package leela_vga_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        BURST      = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/leela_vga_fifo.sv
// Show-ahead synchronous FIFO: the head word is presented whenever not empty.
// Flush wins over push and pop in the same cycle.
module leela_vga_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty   = (count == '0);
    assign rd_en   = pop && !empty && !flush;
    assign wr_en   = push && !flush && ((count != CW'(DEPTH)) || rd_en);
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CW'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/leela_vga_fetch.sv
// Wishbone burst reader for the leela frame buffer feeding the VGA pixel FIFO.
// Handshakes: a Wishbone beat completes on a cycle with stb high and ack (or
// err) high; a pixel word moves on a cycle with pix_valid_o and pix_rd_i high.
module leela_vga_fetch
    import leela_vga_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned FRAME_WORDS = 76800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [31:0] base_adr_i,
    input  logic        frame_start_i,
    input  logic        pix_rd_i,
    output logic [31:0] pix_dat_o,
    output logic        pix_valid_o,
    output logic        underflow_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output state_t      dbg_state_o
);

    localparam int IW = $clog2(FRAME_WORDS + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    state_t          state;
    logic [31:0]     base;
    logic [31:0]     adr;
    logic [IW-1:0]   idx;
    logic [BW-1:0]   left;
    logic            cyc;
    logic            stb;
    logic [2:0]      cti;
    logic            err_q;
    logic            uf_q;

    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic            empty;
    logic [31:0]     rem;
    logic [BW-1:0]   n_first;
    logic [IW-1:0]   idx_skip;
    logic [IW-1:0]   idx_inc;
    logic            space_ok;

    // Words left in the frame decide whether the next burst is shortened.
    assign rem      = FRAME_WORDS - 32'(idx);
    assign n_first  = (rem < BURST_LEN) ? BW'(rem) : BW'(BURST_LEN);
    assign space_ok = (CW'(FIFO_DEPTH) - count) >= CW'(BURST_LEN);
    assign idx_skip = idx + IW'(left);
    assign idx_inc  = idx + IW'(1);

    // A restart discards the data beat and the pop of the same cycle.
    assign push = (state == BURST) && stb && wbm_ack_i && !wbm_err_i && !frame_start_i;
    assign pop  = pix_rd_i && !frame_start_i;

    leela_vga_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (frame_start_i),
        .push     (push),
        .push_dat (wbm_dat_i),
        .pop      (pop),
        .pop_dat  (pix_dat_o),
        .count    (count),
        .empty    (empty)
    );

    // Fetch sequencer: burst scheduling, beat accounting and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            base  <= '0;
            adr   <= '0;
            idx   <= '0;
            left  <= '0;
            cyc   <= 1'b0;
            stb   <= 1'b0;
            cti   <= CTI_CLASSIC;
            err_q <= 1'b0;
            uf_q  <= 1'b0;
        end else if (frame_start_i) begin
            state <= WAIT_SPACE;
            base  <= base_adr_i;
            idx   <= '0;
            left  <= '0;
            cyc   <= 1'b0;
            stb   <= 1'b0;
            cti   <= CTI_CLASSIC;
            err_q <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            if (pix_rd_i && empty) begin
                uf_q <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                end
                WAIT_SPACE: begin
                    if (en_i && space_ok) begin
                        cyc   <= 1'b1;
                        stb   <= 1'b1;
                        adr   <= base + (32'(idx) << 2);
                        left  <= n_first;
                        cti   <= (n_first == BW'(1)) ? CTI_EOB : CTI_INCR;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (stb && wbm_err_i) begin
                        // Abort: skip the rest of this burst's words.
                        cyc   <= 1'b0;
                        stb   <= 1'b0;
                        cti   <= CTI_CLASSIC;
                        err_q <= 1'b1;
                        idx   <= idx_skip;
                        state <= (idx_skip == IW'(FRAME_WORDS)) ? DONE : WAIT_SPACE;
                    end else if (stb && wbm_ack_i) begin
                        idx  <= idx_inc;
                        adr  <= adr + 32'd4;
                        left <= left - BW'(1);
                        if (left == BW'(1)) begin
                            cyc   <= 1'b0;
                            stb   <= 1'b0;
                            cti   <= CTI_CLASSIC;
                            state <= (idx_inc == IW'(FRAME_WORDS)) ? DONE : WAIT_SPACE;
                        end else begin
                            cti <= (left == BW'(2)) ? CTI_EOB : CTI_INCR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pix_valid_o = !empty;
    assign underflow_o = uf_q;
    assign err_o       = err_q;
    assign busy_o      = (state == WAIT_SPACE) || (state == BURST);
    assign wbm_adr_o   = adr;
    assign wbm_dat_o   = 32'h0;
    assign wbm_sel_o   = 4'hF;
    assign wbm_we_o    = 1'b0;
    assign wbm_stb_o   = stb;
    assign wbm_cyc_o   = cyc;
    assign wbm_cti_o   = cti;
    assign wbm_bte_o   = BTE_LINEAR;
    assign dbg_state_o = state;

endmodule
